// File: rtl/cpc_bus_pkg.sv
// -----------------------------------------------------------------------------
// cpc_bus_pkg
// Definitions shared by the CPC bus-timing blocks:
//   - wait_state_e : states of the CPU wait-state generator
//   - MODE_*       : bit positions inside the 3-bit wait-generator mode word
//   - CPC_DIV / CPC_SLOT_PHASE : motherboard default slot geometry
//                    (ce_p pulses per gate-array slot, and the phase that
//                    marks a slot boundary)
// -----------------------------------------------------------------------------
package cpc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        EXTRA = 2'd2
    } wait_state_e;

    localparam int MODE_MEM    = 0;
    localparam int MODE_IO     = 1;
    localparam int MODE_BYPASS = 2;

    localparam int CPC_DIV        = 4;
    localparam int CPC_SLOT_PHASE = 0;

endpackage

// File: rtl/cpc_slot_counter.sv
// -----------------------------------------------------------------------------
// cpc_slot_counter
// Free-running bus-slot phase counter. Advances once per ce_p and wraps from
// DIV-1 to 0. slot_strobe marks the ce_p on which the phase equals SLOT_PHASE,
// i.e. one pulse every DIV ce_p pulses. Also used by the PSG enable path.
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high
//   ce_p        in   CPU positive clock enable; the counter moves only on it
//   phase       out  current phase, 0..DIV-1
//   slot_strobe out  ce_p & (phase == SLOT_PHASE), combinational
// -----------------------------------------------------------------------------
module cpc_slot_counter #(
    parameter int DIV        = 4,
    parameter int SLOT_PHASE = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce_p,
    output logic [$clog2(DIV)-1:0] phase,
    output logic                   slot_strobe
);

    localparam int            PW   = $clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] SLOT = PW'(SLOT_PHASE);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    always_comb begin
        phase_d = phase_q;
        if (ce_p) begin
            // explicit wrap keeps non-power-of-two DIV values correct
            phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase       = phase_q;
    assign slot_strobe = ce_p & (phase_q == SLOT);

endmodule

// File: rtl/cpu_wait_gen.sv
// -----------------------------------------------------------------------------
// cpu_wait_gen
// Z80 bus wait-state generator. Stalls the CPU clock enable so that memory and
// I/O accesses line up with the gate-array bus slot, and stretches I/O accesses
// by IO_EXTRA further whole slots.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no stall; watching for the leading edge of an access
//   ALIGN | stalled, waiting for the next slot boundary
//   EXTRA | stalled, I/O stretch; cnt slot boundaries still to go
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   ce_p         in   CPU positive clock enable; all state advances on it
//   mreq_n       in   memory request, active-low
//   iorq_n       in   I/O request, active-low
//   rfsh_n       in   refresh, active-low (refresh cycles never stall)
//   mode[2:0]    in   [0] memory waits, [1] I/O waits, [2] bypass
//   cpu_cen_p    out  gated clock enable to the CPU
//   wait_n       out  registered, low while a stall is in progress
//   slot_strobe  out  ce_p on the slot-boundary phase
//   phase        out  current slot phase
// -----------------------------------------------------------------------------
module cpu_wait_gen
    import cpc_bus_pkg::*;
#(
    parameter int DIV        = CPC_DIV,
    parameter int SLOT_PHASE = CPC_SLOT_PHASE,
    parameter int IO_EXTRA   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce_p,
    input  logic                   mreq_n,
    input  logic                   iorq_n,
    input  logic                   rfsh_n,
    input  logic [2:0]             mode,
    output logic                   cpu_cen_p,
    output logic                   wait_n,
    output logic                   slot_strobe,
    output logic [$clog2(DIV)-1:0] phase
);

    localparam logic [3:0] EXTRA_CNT = 4'(IO_EXTRA);
    localparam bit         HAS_EXTRA = (IO_EXTRA > 0);

    wait_state_e state_q, state_d;
    logic        wait_n_q, wait_n_d;
    logic        old_acc_q, old_acc_d;
    logic        is_io_q, is_io_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        acc;
    logic        start;
    logic        start_io;
    logic        eligible;
    logic        strobe;

    cpc_slot_counter #(
        .DIV        (DIV),
        .SLOT_PHASE (SLOT_PHASE)
    ) u_slot (
        .clk         (clk),
        .reset       (reset),
        .ce_p        (ce_p),
        .phase       (phase),
        .slot_strobe (strobe)
    );

    // Refresh cycles drive mreq_n low too; rfsh_n masks them out.
    assign acc      = (~mreq_n & rfsh_n) | ~iorq_n;
    assign start    = ~old_acc_q & acc;
    assign start_io = ~iorq_n;
    assign eligible = start_io ? mode[MODE_IO] : mode[MODE_MEM];

    always_comb begin
        state_d   = state_q;
        wait_n_d  = wait_n_q;
        old_acc_d = old_acc_q;
        is_io_d   = is_io_q;
        cnt_d     = cnt_q;

        if (ce_p) begin
            old_acc_d = acc;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_io_d = start_io;
                        if (eligible) begin
                            if (!strobe) begin
                                state_d  = ALIGN;
                                wait_n_d = 1'b0;
                            end else if (start_io && HAS_EXTRA) begin
                                // already on the boundary: only the stretch remains
                                state_d  = EXTRA;
                                cnt_d    = EXTRA_CNT;
                                wait_n_d = 1'b0;
                            end
                        end
                    end
                end
                ALIGN: begin
                    // acc can only drop here while bypassed (CPU not frozen)
                    if (!acc) begin
                        state_d  = IDLE;
                        wait_n_d = 1'b1;
                    end else if (strobe) begin
                        if (!is_io_q || !HAS_EXTRA) begin
                            state_d  = IDLE;
                            wait_n_d = 1'b1;
                        end else begin
                            state_d = EXTRA;
                            cnt_d   = EXTRA_CNT;
                        end
                    end
                end
                EXTRA: begin
                    if (!acc) begin
                        state_d  = IDLE;
                        wait_n_d = 1'b1;
                    end else if (strobe) begin
                        cnt_d = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_d  = IDLE;
                            wait_n_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d  = IDLE;
                    wait_n_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wait_n_q  <= 1'b1;
            old_acc_q <= 1'b0;
            is_io_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wait_n_q  <= wait_n_d;
            old_acc_q <= old_acc_d;
            is_io_q   <= is_io_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wait_n      = wait_n_q;
    assign slot_strobe = strobe;
    // Bypass acts immediately, independent of the registered stall state.
    assign cpu_cen_p   = ce_p & (wait_n_q | mode[MODE_BYPASS]);

endmodule

// File: tb/tb_cpu_wait_gen.sv
module tb_cpu_wait_gen;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       ce_p   = 1'b0;
    logic       mreq_n = 1'b1;
    logic       iorq_n = 1'b1;
    logic       rfsh_n = 1'b1;
    logic [2:0] mode   = 3'b011;
    logic       cpu_cen_p;
    logic       wait_n;
    logic       slot_strobe;
    logic [1:0] phase;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string tag;
        int    supp;
        int    wl;
    } exp_t;

    exp_t sb[$];

    int m_phase   = 0;
    int stray     = 0;
    int stray_wl  = 0;
    int phase_err = 0;

    cpu_wait_gen #(
        .DIV        (4),
        .SLOT_PHASE (0),
        .IO_EXTRA   (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ce_p        (ce_p),
        .mreq_n      (mreq_n),
        .iorq_n      (iorq_n),
        .rfsh_n      (rfsh_n),
        .mode        (mode),
        .cpu_cen_p   (cpu_cen_p),
        .wait_n      (wait_n),
        .slot_strobe (slot_strobe),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    // ce_p high on every other clk, changed just after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ce_p = ~ce_p;
        end
    end

    // reference phase counter
    always @(posedge clk) begin
        if (reset)     m_phase <= 0;
        else if (ce_p) m_phase <= (m_phase == 3) ? 0 : m_phase + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Monitor: an access window is any bus strobe low. While it is open,
    // count suppressed ce_p pulses and ce_p pulses seen with wait_n low; on
    // close, pop the expected record and compare.
    initial begin : monitor
        bit   in_win;
        int   supp;
        int   wl;
        exp_t e;
        in_win = 1'b0;
        supp   = 0;
        wl     = 0;
        forever begin
            @(negedge clk);
            if (int'(phase) != m_phase) phase_err++;
            if (!mreq_n || !iorq_n) begin
                in_win = 1'b1;
                if (ce_p && !cpu_cen_p) supp++;
                if (ce_p && !wait_n)    wl++;
            end else begin
                if (ce_p && !cpu_cen_p) stray++;
                if (ce_p && !wait_n)    stray_wl++;
                if (in_win) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_access", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk({e.tag, "_suppressed"}, supp, e.supp);
                        chk({e.tag, "_waitlow"}, wl, e.wl);
                    end
                    in_win = 1'b0;
                    supp   = 0;
                    wl     = 0;
                end
            end
        end
    end

    // Wait until the coming posedge carries ce_p at model phase p.
    task automatic wait_phase(input string tag, input int p);
        int guard;
        guard = 0;
        @(posedge clk);
        #2;
        while (!(ce_p && m_phase == p) && guard < 100) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (guard >= 100) chk({tag, "_phase_timeout"}, 1, 0);
    endtask

    // kind: 0 memory, 1 I/O, 2 refresh. The access is held until the CPU has
    // received cpu_len enabled ce_p pulses after the detecting one.
    task automatic do_access(input string tag, input int kind, input int p,
                             input int cpu_len, input int exp_supp, input int exp_wl);
        int  n;
        int  guard;
        bit  en;
        exp_t e;
        wait_phase(tag, p);
        e.tag  = tag;
        e.supp = exp_supp;
        e.wl   = exp_wl;
        sb.push_back(e);
        case (kind)
            0: begin mreq_n = 1'b0; rfsh_n = 1'b1; end
            1: begin iorq_n = 1'b0; end
            default: begin mreq_n = 1'b0; rfsh_n = 1'b0; end
        endcase
        @(posedge clk);
        #2;
        n     = 0;
        guard = 0;
        while (n < cpu_len && guard < 200) begin
            @(negedge clk);
            en = ce_p && cpu_cen_p;
            @(posedge clk);
            #2;
            if (en) n++;
            guard++;
        end
        if (guard >= 200) chk({tag, "_hold_timeout"}, 1, 0);
        mreq_n = 1'b1;
        iorq_n = 1'b1;
        rfsh_n = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   scount;
        int   align_err;
        int   cen_err;
        exp_t e;

        // reset held for 3 clks
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_wait_n", wait_n, 1);
            chk("rst_phase", int'(phase), 0);
            chk("rst_cen_mirror", cpu_cen_p, ce_p);
            chk("rst_strobe_mirror", slot_strobe, ce_p);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (4) @(posedge clk);

        mode = 3'b011;
        do_access("mem_ph1",  0, 1, 2, 3, 3);
        do_access("mem_ph0",  0, 0, 2, 0, 0);
        do_access("mem_ph2",  0, 2, 2, 2, 2);
        do_access("mem_ph3",  0, 3, 2, 1, 1);
        do_access("rfsh_ph1", 2, 1, 2, 0, 0);
        do_access("io_ph2",   1, 2, 2, 6, 6);
        do_access("io_ph0",   1, 0, 2, 4, 4);
        do_access("io_ph3",   1, 3, 2, 5, 5);

        // reset while in ALIGN
        wait_phase("rst_mid", 1);
        e.tag  = "rst_mid";
        e.supp = 1;
        e.wl   = 1;
        sb.push_back(e);
        mreq_n = 1'b0;
        @(posedge clk);
        #2;
        @(negedge clk);
        chk("mid_wait_low", wait_n, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        mreq_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_wait_n", wait_n, 1);
        chk("mid_rst_phase", int'(phase), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (6) @(posedge clk);

        mode = 3'b010;
        do_access("m010_mem_ph1", 0, 1, 2, 0, 0);
        do_access("m010_io_ph1",  1, 1, 2, 7, 7);

        mode = 3'b001;
        do_access("m001_io_ph2",  1, 2, 2, 0, 0);

        mode = 3'b111;
        do_access("byp_io_ph1",   1, 1, 7, 0, 7);
        do_access("byp_mem_ph3",  0, 3, 2, 0, 1);
        // released while in EXTRA: one further ce_p with wait_n low outside
        // the window, then back to IDLE
        do_access("byp_io_ph3",   1, 3, 2, 0, 2);

        scount    = 0;
        align_err = 0;
        cen_err   = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (ce_p && slot_strobe) scount++;
            if (slot_strobe != (ce_p && m_phase == 0)) align_err++;
            if (cpu_cen_p != ce_p) cen_err++;
        end
        chk("slot_strobe_count_400", scount, 100);
        chk("slot_strobe_alignment", align_err, 0);
        chk("bypass_cen_mirror", cen_err, 0);

        chk("stray_stall", stray, 0);
        chk("stray_waitlow", stray_wl, 1);
        chk("phase_tracking", phase_err, 0);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_wait_gen.md
# cpu_wait_gen

Parametrised Z80 bus wait-state generator for the CPC core. It aligns CPU memory and I/O accesses to the gate-array bus slot, and adds a configurable I/O stretch. It drives the gated positive clock enable to the T80pa, sitting between the clock-enable generator and the CPU in the motherboard.

## Interface
Parameters:
- DIV, 4: ce_p pulses per bus slot; must be ≥2.
- SLOT_PHASE, 0: phase value (0..DIV-1) on which a slot boundary occurs.
- IO_EXTRA, 1: additional whole slots inserted after alignment for I/O accesses (0..15).

Ports:
- clk, in, 1: system clock; single clock domain.
- reset, in, 1: synchronous, active-high.
- ce_p, in, 1: CPU positive-edge clock enable; all state advances only on ce_p.
- mreq_n, iorq_n, rfsh_n, in, 1 each: CPU bus strobes, active-low.
- mode, in, 3: [0] enable memory waits, [1] enable I/O waits, [2] bypass (CPU never stalled).
- cpu_cen_p, out, 1: ce_p & (wait_n | mode[2]); feeds the CPU cen_p.
- wait_n, out, 1: registered, low while a stall is in progress.
- slot_strobe, out, 1: ce_p & (phase == SLOT_PHASE); combinational, 1 MHz-style timing pulse.
- phase, out, clog2(DIV): current slot phase counter.

## Operation
- Phase counter: on each ce_p, phase <= (phase == DIV-1) ? 0 : phase+1.
- Access term: acc = (~mreq_n & rfsh_n) | ~iorq_n. Refresh cycles (mreq_n=0, rfsh_n=0) are never accesses.
- Edge detect: old_acc <= acc on each ce_p. The start condition is ~old_acc & acc, evaluated at ce_p.
- Access class is latched at start: is_io = ~iorq_n.
- The access is eligible when (is_io ? mode[1] : mode[0]).
- State machine: IDLE, ALIGN, EXTRA.
- IDLE, eligible start, phase ≠ SLOT_PHASE: go to ALIGN; wait_n <= 0.
- IDLE, eligible start, phase == SLOT_PHASE:
  - Memory access: stay in IDLE with no wait.
  - I/O access with IO_EXTRA > 0: go to EXTRA; cnt <= IO_EXTRA; wait_n <= 0.
- IDLE, ineligible start: no action.
- ALIGN, at slot_strobe:
  - Memory access, or IO_EXTRA = 0: go to IDLE; wait_n <= 1.
  - Otherwise: go to EXTRA; cnt <= IO_EXTRA.
- EXTRA, at slot_strobe: cnt <= cnt-1. When cnt reaches 1 on that strobe, go to IDLE; wait_n <= 1.
- ALIGN/EXTRA, acc deasserted (possible only under bypass): go to IDLE; wait_n <= 1.
- mode changes are sampled at the start event only. mode[2] acts combinationally on cpu_cen_p at all times; wait_n keeps being generated while bypassed.
- A new start is not honoured outside IDLE. A new access cannot occur while the CPU is frozen.

## Timing
- Reset values: phase=0, state=IDLE, wait_n=1, old_acc=0, cnt=0. cpu_cen_p=ce_p and slot_strobe=ce_p from the first cycle after reset.
- Reset mid-stall: wait_n=1 on the next clk. Phase restarts at 0.
- wait_n changes only on clk edges where ce_p=1. It is low starting with the ce_p following detection, so the detecting ce_p itself still reaches the CPU.
- Memory stall length in suppressed ce_p pulses: (SLOT_PHASE - phase_at_detect) mod DIV.
- I/O stall length: that memory figure plus IO_EXTRA·DIV (when phase_at_detect == SLOT_PHASE, the alignment part is zero).
- Phase wrap: DIV-1 → 0 with no skipped phase. slot_strobe occurs exactly once per DIV ce_p pulses.
- Simultaneous reset and ce_p: reset wins.

## Structure
- Shared package cpc_bus_pkg holds:
  - the state enum (IDLE/ALIGN/EXTRA);
  - the mode bit index constants MODE_MEM=0, MODE_IO=1, MODE_BYPASS=2;
  - the default DIV/SLOT_PHASE constants used by the motherboard.
- One natural sub-module, cpc_slot_counter: the phase counter plus slot_strobe, reusable by the PSG enable path.
- The FSM stays in cpu_wait_gen.

## Test plan
All scenarios use DIV=4, SLOT_PHASE=0, IO_EXTRA=1, mode=3'b011 unless stated.
- Reset: hold reset 3 clks → wait_n=1, phase=0, cpu_cen_p mirrors ce_p. Assert reset during ALIGN → wait_n=1 on the next clk.
- Memory read starting at phase 1 → wait_n low for 3 ce_p pulses (phases 2, 3, 0 suppressed), high again after the phase-0 strobe.
- Memory read starting at phase 0 → no wait_n low. Refresh cycle (mreq_n=0, rfsh_n=0) at phase 1 → no wait.
- I/O write starting at phase 2 → 6 ce_p pulses suppressed (3, 0, 1, 2, 3, 0). Starting at phase 0 → exactly 4 suppressed.
- mode=3'b010: memory access at phase 1 → no wait; I/O access still stalls.
- mode=3'b111: I/O access at phase 1 → wait_n toggles as normal, but cpu_cen_p never drops a ce_p pulse. slot_strobe counted over 400 ce_p pulses = 100.
